// File: rtl/pipe_stage_chain_if.sv
// Signal bundle between a pipe_stage_chain and its hazard/control logic:
// stage-0 input handshake, per-stage stall/flush, stage state and tag lookups.
interface pipe_stage_chain_if #(
  parameter int DW     = 32,
  parameter int STAGES = 4,
  parameter int TW     = 5,
  parameter int NLK    = 2
);
  logic                  in_valid;
  logic [DW-1:0]         in_data;
  logic [TW-1:0]         in_tag;
  logic                  in_we;
  logic                  in_ready;
  logic [STAGES-1:0]     stall;
  logic [STAGES-1:0]     flush;
  logic [STAGES-1:0]     stage_valid;
  logic [STAGES*DW-1:0]  stage_data;
  logic [STAGES*TW-1:0]  stage_tag;
  logic [STAGES-1:0]     stage_we;
  logic [NLK*TW-1:0]     lk_tag;
  logic [NLK-1:0]        lk_hit;
  logic [NLK*3-1:0]      lk_stage;

  // Control side: feeds ops, stalls/flushes stages, queries producers.
  modport master (
    output in_valid, in_data, in_tag, in_we, stall, flush, lk_tag,
    input  in_ready, stage_valid, stage_data, stage_tag, stage_we,
           lk_hit, lk_stage
  );

  // Pipeline side.
  modport slave (
    input  in_valid, in_data, in_tag, in_we, stall, flush, lk_tag,
    output in_ready, stage_valid, stage_data, stage_tag, stage_we,
           lk_hit, lk_stage
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// Generic chain of STAGES pipeline registers with stall/flush/bubble control
// and youngest-producer tag lookup. Optional counters: PIPE_STAGE_CHAIN_PERF_EN.
module pipe_stage_chain #(
  parameter int DW     = 32,
  parameter int STAGES = 4,
  parameter int TW     = 5,
  parameter int NLK    = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
`ifdef PIPE_STAGE_CHAIN_PERF_EN
  output logic [31:0]        o_bubble_cnt,
  output logic [31:0]        o_flush_cnt,
  output logic [31:0]        o_retire_cnt,
`endif
  pipe_stage_chain_if.slave  bus
);

  logic [STAGES-1:0]          r_valid;
  logic [STAGES-1:0]          r_we;
  logic [STAGES-1:0][DW-1:0]  r_data;
  logic [STAGES-1:0][TW-1:0]  r_tag;

  logic [STAGES-1:0]          w_hold;
  logic [STAGES-1:0]          w_bubble;
  logic [STAGES-1:0]          w_src_valid;
  logic [STAGES-1:0]          w_src_we;
  logic [STAGES-1:0][DW-1:0]  w_src_data;
  logic [STAGES-1:0][TW-1:0]  w_src_tag;

  logic [NLK-1:0][TW-1:0]     w_lk_tag;
  logic [NLK-1:0]             w_lk_hit;
  logic [NLK-1:0][2:0]        w_lk_stage;

  // A stall anywhere downstream freezes this stage; the first non-held
  // stage after a held one takes a bubble.
  always_comb begin
    w_hold   = '0;
    w_bubble = '0;
    for (int i = 0; i < STAGES; i++) begin
      w_hold[i] = |(bus.stall >> i);
    end
    for (int i = 1; i < STAGES; i++) begin
      w_bubble[i] = w_hold[i-1] & ~w_hold[i];
    end
  end

  assign w_src_valid = {r_valid[STAGES-2:0], bus.in_valid};
  assign w_src_we    = {r_we[STAGES-2:0],    bus.in_we};
  assign w_src_data  = {r_data[STAGES-2:0],  bus.in_data};
  assign w_src_tag   = {r_tag[STAGES-2:0],   bus.in_tag};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
      r_we    <= '0;
      r_data  <= '0;
      r_tag   <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (bus.flush[i] || w_bubble[i]) begin
          r_valid[i] <= 1'b0;
          r_we[i]    <= 1'b0;
          r_data[i]  <= '0;
          r_tag[i]   <= '0;
        end else if (!w_hold[i]) begin
          r_valid[i] <= w_src_valid[i];
          r_we[i]    <= w_src_we[i];
          r_data[i]  <= w_src_data[i];
          r_tag[i]   <= w_src_tag[i];
        end
      end
    end
  end

  // Scan oldest to youngest so the youngest match wins.
  assign w_lk_tag = bus.lk_tag;

  always_comb begin
    w_lk_hit   = '0;
    w_lk_stage = '0;
    for (int k = 0; k < NLK; k++) begin
      for (int i = STAGES - 1; i >= 0; i--) begin
        if (r_valid[i] && r_we[i] && (r_tag[i] == w_lk_tag[k]) &&
            (w_lk_tag[k] != '0)) begin
          w_lk_hit[k]   = 1'b1;
          w_lk_stage[k] = 3'(i);
        end
      end
    end
  end

  assign bus.in_ready    = ~w_hold[0];
  assign bus.stage_valid = r_valid;
  assign bus.stage_we    = r_we;
  assign bus.stage_data  = r_data;
  assign bus.stage_tag   = r_tag;
  assign bus.lk_hit      = w_lk_hit;
  assign bus.lk_stage    = w_lk_stage;

`ifdef PIPE_STAGE_CHAIN_PERF_EN
  logic        w_ev_bubble;
  logic        w_ev_flush;
  logic        w_ev_retire;
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_flush_cnt;
  logic [31:0] r_retire_cnt;

  // A flushed stage does not count as a bubble even if it sits after a hold.
  assign w_ev_bubble = |(w_bubble & ~bus.flush);
  assign w_ev_flush  = |(bus.flush & r_valid);
  assign w_ev_retire = r_valid[STAGES-1] & ~w_hold[STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
      r_retire_cnt <= '0;
    end else begin
      if (w_ev_bubble && (r_bubble_cnt != '1)) r_bubble_cnt <= r_bubble_cnt + 32'd1;
      if (w_ev_flush  && (r_flush_cnt  != '1)) r_flush_cnt  <= r_flush_cnt  + 32'd1;
      if (w_ev_retire && (r_retire_cnt != '1)) r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign o_bubble_cnt = r_bubble_cnt;
  assign o_flush_cnt  = r_flush_cnt;
  assign o_retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: directed vector table, corner-case
// sequences and randomized traffic against a stage-list reference model.
module tb_pipe_stage_chain;
  localparam int DW  = 32;
  localparam int ST  = 4;
  localparam int TW  = 5;
  localparam int NLK = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_stage_chain_if #(.DW(DW), .STAGES(ST), .TW(TW), .NLK(NLK)) bus ();

`ifdef PIPE_STAGE_CHAIN_PERF_EN
  logic [31:0] bubble_cnt, flush_cnt, retire_cnt;
`endif

  pipe_stage_chain #(.DW(DW), .STAGES(ST), .TW(TW), .NLK(NLK)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    .o_bubble_cnt (bubble_cnt),
    .o_flush_cnt  (flush_cnt),
    .o_retire_cnt (retire_cnt),
`endif
    .bus          (bus)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [4:0]  t;
    logic        w;
  } op_t;

  op_t         m [ST];
  int unsigned m_bub, m_fl, m_ret;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: the highest stalled index bounds the frozen region; the
  // stage right after it is the bubble slot, everything beyond shifts.
  task automatic model_step();
    op_t nm [ST];
    op_t z;
    op_t inop;
    int  hmax;
    bit  bub, fl;
    z    = '{1'b0, 32'h0, 5'h0, 1'b0};
    inop = '{bus.in_valid, bus.in_data, bus.in_tag, bus.in_we};
    hmax = -1;
    bub  = 0;
    fl   = 0;
    for (int i = 0; i < ST; i++) if (bus.stall[i]) hmax = i;
    if (rst) begin
      for (int i = 0; i < ST; i++) nm[i] = z;
      m_bub = 0; m_fl = 0; m_ret = 0;
    end else begin
      for (int i = 0; i < ST; i++) begin
        if (bus.flush[i]) begin
          if (m[i].v) fl = 1;
          nm[i] = z;
        end else if (i <= hmax) nm[i] = m[i];
        else if (i == hmax + 1 && i > 0) begin
          nm[i] = z;
          bub = 1;
        end else nm[i] = (i == 0) ? inop : m[i-1];
      end
      if (bub && m_bub != 32'hFFFF_FFFF) m_bub++;
      if (fl && m_fl != 32'hFFFF_FFFF) m_fl++;
      if (m[ST-1].v && hmax < ST - 1 && m_ret != 32'hFFFF_FFFF) m_ret++;
    end
    for (int i = 0; i < ST; i++) m[i] = nm[i];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic compare_all(input string tag);
    logic [ST-1:0]    ev, ew;
    logic [ST*DW-1:0] ed;
    logic [ST*TW-1:0] et;
    logic [NLK-1:0]   eh;
    logic [NLK*3-1:0] es;
    logic [TW-1:0]    q;
    int               found [$];
    for (int i = 0; i < ST; i++) begin
      ev[i] = m[i].v;
      ew[i] = m[i].w;
      ed[i*DW +: DW] = m[i].d;
      et[i*TW +: TW] = m[i].t;
    end
    eh = '0;
    es = '0;
    for (int k = 0; k < NLK; k++) begin
      q = bus.lk_tag[k*TW +: TW];
      found.delete();
      for (int i = 0; i < ST; i++)
        if (q != 0 && m[i].v && m[i].w && m[i].t == q) found.push_back(i);
      if (found.size() > 0) begin
        eh[k] = 1'b1;
        es[k*3 +: 3] = 3'(found[0]);
      end
    end
    check({tag, ".valid"}, 128'(bus.stage_valid), 128'(ev));
    check({tag, ".data"},  128'(bus.stage_data),  128'(ed));
    check({tag, ".tag"},   128'(bus.stage_tag),   128'(et));
    check({tag, ".we"},    128'(bus.stage_we),    128'(ew));
    check({tag, ".ready"}, 128'(bus.in_ready),    128'(bus.stall == '0));
    check({tag, ".lkhit"}, 128'(bus.lk_hit),      128'(eh));
    check({tag, ".lkstg"}, 128'(bus.lk_stage),    128'(es));
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    check({tag, ".bubcnt"}, 128'(bubble_cnt), 128'(m_bub));
    check({tag, ".flcnt"},  128'(flush_cnt),  128'(m_fl));
    check({tag, ".retcnt"}, 128'(retire_cnt), 128'(m_ret));
`endif
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic [4:0] t, input logic w,
                       input logic [3:0] st, input logic [3:0] fl, input logic [9:0] lk);
    bus.in_valid = iv;
    bus.in_data  = d;
    bus.in_tag   = t;
    bus.in_we    = w;
    bus.stall    = st;
    bus.flush    = fl;
    bus.lk_tag   = lk;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 5'h0, 1'b0, 4'h0, 4'h0, 10'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic [4:0]  t;
    logic        w;
    logic [3:0]  st;
    logic [3:0]  fl;
    logic [4:0]  lk;
    logic [3:0]  ev;
    logic [31:0] ed3;
    logic        eh;
    logic [2:0]  es;
    logic        er;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{1'b1, 32'h11, 5'd3, 1'b1, 4'b0000, 4'b0000, 5'd3, 4'b0001, 32'h00, 1'b1, 3'd0, 1'b1};
    tbl[1] = '{1'b1, 32'h22, 5'd4, 1'b1, 4'b0000, 4'b0000, 5'd3, 4'b0011, 32'h00, 1'b1, 3'd1, 1'b1};
    tbl[2] = '{1'b1, 32'h33, 5'd3, 1'b0, 4'b0000, 4'b0000, 5'd3, 4'b0111, 32'h00, 1'b1, 3'd2, 1'b1};
    tbl[3] = '{1'b1, 32'h44, 5'd5, 1'b1, 4'b0000, 4'b0000, 5'd3, 4'b1111, 32'h11, 1'b1, 3'd3, 1'b1};
    tbl[4] = '{1'b0, 32'h55, 5'd0, 1'b0, 4'b0100, 4'b0000, 5'd3, 4'b0111, 32'h00, 1'b0, 3'd0, 1'b0};
    tbl[5] = '{1'b0, 32'h55, 5'd0, 1'b0, 4'b0100, 4'b0000, 5'd3, 4'b0111, 32'h00, 1'b0, 3'd0, 1'b0};
    tbl[6] = '{1'b0, 32'h66, 5'd0, 1'b0, 4'b0000, 4'b0000, 5'd4, 4'b1110, 32'h22, 1'b1, 3'd3, 1'b1};
    tbl[7] = '{1'b1, 32'h77, 5'd5, 1'b1, 4'b1000, 4'b0010, 5'd5, 4'b1100, 32'h22, 1'b0, 3'd0, 1'b0};
    tbl[8] = '{1'b1, 32'h77, 5'd5, 1'b1, 4'b0000, 4'b0000, 5'd5, 4'b1001, 32'h33, 1'b1, 3'd0, 1'b1};
    tbl[9] = '{1'b0, 32'h00, 5'd0, 1'b0, 4'b0000, 4'b0001, 5'd0, 4'b0010, 32'h00, 1'b0, 3'd0, 1'b1};

    for (int i = 0; i < ST; i++) m[i] = '{1'b0, 32'h0, 5'h0, 1'b0};
    m_bub = 0; m_fl = 0; m_ret = 0;

    // Reset state
    do_reset();
    tick();
    check("rst.valid", 128'(bus.stage_valid), 128'(0));
    check("rst.data",  128'(bus.stage_data),  128'(0));
    check("rst.lkhit", 128'(bus.lk_hit),      128'(0));
    compare_all("rst");

    // Directed vector table: streaming, middle stall, flush over hold
    for (int n = 0; n < 10; n++) begin
      drive(tbl[n].iv, tbl[n].d, tbl[n].t, tbl[n].w, tbl[n].st, tbl[n].fl, {5'd0, tbl[n].lk});
      tick();
      check($sformatf("vec%0d.valid", n), 128'(bus.stage_valid),       128'(tbl[n].ev));
      check($sformatf("vec%0d.d3", n),    128'(bus.stage_data[127:96]), 128'(tbl[n].ed3));
      check($sformatf("vec%0d.hit", n),   128'(bus.lk_hit[0]),          128'(tbl[n].eh));
      check($sformatf("vec%0d.stg", n),   128'(bus.lk_stage[2:0]),      128'(tbl[n].es));
      check($sformatf("vec%0d.rdy", n),   128'(bus.in_ready),           128'(tbl[n].er));
`ifdef PIPE_STAGE_CHAIN_PERF_EN
      if (n == 5) check("perf.bubble2", 128'(bubble_cnt), 128'(2));
      if (n == 7) check("perf.flush1",  128'(flush_cnt),  128'(1));
`endif
      compare_all($sformatf("vec%0d", n));
    end

    // Reset in the middle of full traffic
    for (int i = 0; i < ST; i++) begin
      drive(1'b1, 32'hA0 + 32'(i), 5'(i + 1), 1'b1, 4'h0, 4'h0, {5'd2, 5'd1});
      tick();
    end
    check("mid.full", 128'(bus.stage_valid), 128'(4'b1111));
    check("mid.prehit", 128'(bus.lk_hit), 128'(2'b11));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid.valid", 128'(bus.stage_valid), 128'(0));
    check("mid.data",  128'(bus.stage_data),  128'(0));
    check("mid.lkhit", 128'(bus.lk_hit),      128'(0));
    compare_all("mid");

    // Lookup priority: youngest we=1 producer wins, we=0 ignored
    drive(1'b1, 32'hB1, 5'd7, 1'b1, 4'h0, 4'h0, 10'h0); tick();
    drive(1'b1, 32'hB2, 5'd7, 1'b0, 4'h0, 4'h0, 10'h0); tick();
    drive(1'b1, 32'hB3, 5'd7, 1'b1, 4'h0, 4'h0, 10'h0); tick();
    drive(1'b1, 32'hB4, 5'd9, 1'b1, 4'h0, 4'h0, 10'h0); tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 4'h0, 4'h0, {5'd9, 5'd7});
    #1;
    check("prio.hit",   128'(bus.lk_hit),   128'(2'b11));
    check("prio.stage", 128'(bus.lk_stage), 128'({3'd0, 3'd1}));
    drive(1'b0, 32'h0, 5'd0, 1'b0, 4'b1000, 4'b0010, {5'd9, 5'd7});
    tick();
    check("prio.flush.hit",   128'(bus.lk_hit[0]),     128'(1));
    check("prio.flush.stage", 128'(bus.lk_stage[2:0]), 128'(3));
    compare_all("prio");

    // Tag zero never matches; invalid stage never matches
    do_reset();
    drive(1'b1, 32'hC0, 5'd0, 1'b1, 4'h0, 4'h0, 10'h0);
    tick();
    check("tag0.valid", 128'(bus.stage_valid[0]), 128'(1));
    check("tag0.hit",   128'(bus.lk_hit),         128'(0));
    drive(1'b0, 32'hC1, 5'd6, 1'b1, 4'h0, 4'h0, {5'd6, 5'd6});
    tick();
    check("inval.hit", 128'(bus.lk_hit), 128'(0));
    compare_all("inval");

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive(1'($urandom), $urandom, 5'($urandom_range(0, 7)), 1'($urandom),
            ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
            ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0,
            {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))});
      tick();
      compare_all("rnd");
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
- Parametrised chain of STAGES pipeline registers. Replaces hand-packed per-stage register banks with one generic block.
- Each stage carries DW data bits plus a valid bit, a destination tag, and a write-enable flag.
- Per-stage stall and flush; stall propagates upstream, and a bubble is inserted downstream of a held stage.
- Built-in tag-lookup ports report the youngest in-flight producer of a register. The hazard unit uses them for forwarding and stall decisions.

Parameters:
- DW, 32, payload width per stage (1..256)
- STAGES, 4, number of register stages (2..8); stage 0 is youngest
- TW, 5, destination tag width
- NLK, 2, number of tag-lookup ports (1..4)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  stage-0 input valid
- in_data  in  DW  stage-0 input payload
- in_tag  in  TW  destination tag of incoming op
- in_we  in  1  incoming op writes its tag
- stall  in  STAGES  stall[i] requests stage i to hold
- flush  in  STAGES  flush[i] kills stage i at next edge
- in_ready  out  1  stage 0 accepts this cycle (= ~hold[0])
- stage_valid  out  STAGES  valid per stage
- stage_data  out  STAGES*DW  stage i at [i*DW +: DW]
- stage_tag  out  STAGES*TW  stage i at [i*TW +: TW]
- stage_we  out  STAGES  write-enable per stage
- lk_tag  in  NLK*TW  lookup tags, port k at [k*TW +: TW]
- lk_hit  out  NLK  port k found a producer
- lk_stage  out  NLK*3  index of youngest matching stage, port k at [k*3 +: 3]

Behaviour:
- Clock and reset: single clock; rst is synchronous and active-high, sampled on the rising edge of clk.
- On rst, every stage clears to valid=0, data=0, tag=0, we=0. Lookup outputs therefore read hit=0, stage=0.
- Hold: hold[i] = OR of stall[i..STAGES-1]. A stall in any later stage freezes stage i and every earlier stage.
- Per-stage update at each edge, in priority order:
  1. rst: clear the stage.
  2. flush[i]: clear the stage (valid, data, tag, we all 0). Flush overrides hold.
  3. hold[i]: retain the stage contents.
  4. i>0 and hold[i-1]: bubble; clear the stage.
  5. Otherwise load the stage: stage 0 takes in_*; stage i takes stage i-1.
- Last stage: retires every cycle it is not held; there is no downstream backpressure.
- Latency: an op entering at cycle t appears in stage i at cycle t+1+i, plus the number of cycles it was held.
- Stage-0 flush with in_valid=1 discards the input. in_ready still reports ~hold[0].
- Stage-0 load copies in_data, in_tag, and in_we unconditionally; stage_valid[0] takes in_valid.
- Lookup (combinational, same cycle):
  - A match at stage i requires stage_valid[i], stage_we[i], stage_tag[i]==lk_tag, and lk_tag!=0.
  - lk_stage is the lowest matching index (youngest producer). lk_hit=0 gives lk_stage=0.
  - Tag 0 never matches.
- Lookup sees the registered stage state only. Same-cycle input (in_*) is not searched.
- All flattened buses are little-endian by stage index.

Optional Feature:
- Macro: PIPE_STAGE_CHAIN_PERF_EN.
- When defined, three extra outputs are added: bubble_cnt[31:0], flush_cnt[31:0], retire_cnt[31:0].
  - bubble_cnt: +1 per edge where any stage takes the bubble path.
  - flush_cnt: +1 per edge where any flush[i] hits a valid stage.
  - retire_cnt: +1 per edge where the last stage is valid and not held.
  - All three counters saturate at 0xFFFFFFFF and clear on rst.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-traffic: fill all 4 stages with valid ops, then assert rst for 1 cycle -> next cycle stage_valid=0000, stage_data all 0, lk_hit=0.
- Streaming, no stall: inject data 0x11,0x22,0x33,0x44 on consecutive cycles -> 0x11 appears in stage 3 exactly 4 edges after its acceptance; in_ready stays 1.
- Middle stall: stall=0100 for 2 cycles with the pipe full -> stages 0..2 retained, stage 3 receives bubbles (valid=0) for 2 edges, in_ready=0; release -> flow resumes without duplicating or losing ops; bubble_cnt=2 when PERF_EN is defined.
- Flush beats hold: stall=1000 and flush=0010 together on a full pipe -> stage 1 cleared, stages 0, 2, 3 unchanged; flush_cnt=1 when PERF_EN is defined.
- Lookup priority: stage 1 holds tag 7 we=1, stage 3 holds tag 7 we=1, stage 2 holds tag 7 we=0; lk_tag=7 -> lk_hit=1, lk_stage=1. Flush stage 1 -> lk_stage=3 next cycle.
- Tag zero and invalid stages: stage 0 holds tag 0 we=1; lk_tag=0 -> lk_hit=0. A stage with valid=0 and a matching tag -> lk_hit=0.
